// File: rtl/gpio_in_filter.sv
// gpio_in_filter
//
// Input conditioning between the pad receive outputs and the core. Each pin
// has its own independent logic:
//   - a two-flop synchronizer (s1, s2). It always runs, even when the pin
//     is disabled.
//   - a glitch filter. A change at s2 is accepted only after it has held
//     for filt_len_i + 1 consecutive enabled cycles.
//   - one-cycle rise/fall strobes. They are aligned with the first cycle
//     in which the new level shows on gpio_o.
//   - a sticky event flag per pin. If set and clear occur in the same
//     cycle, set wins.
//   - a registered OR of all event flags, driven out as irq_o.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset, clears every flop
//   pad_c_i    raw pad receive values (asynchronous to clk)
//   en_i       per-pin filter enable
//   filt_len_i global filter length L (sampled every cycle)
//   evt_clr_i  per-pin clear of the sticky event flag
//   gpio_o     filtered, synchronized level
//   rise_o     one-cycle strobe on an accepted 0->1 change
//   fall_o     one-cycle strobe on an accepted 1->0 change
//   evt_o      sticky edge-event flags
//   irq_o      registered OR of evt_o
module gpio_in_filter #(
    parameter int N_PINS = 9,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PINS-1:0] pad_c_i,
    input  logic [N_PINS-1:0] en_i,
    input  logic [CNT_W-1:0]  filt_len_i,
    input  logic [N_PINS-1:0] evt_clr_i,
    output logic [N_PINS-1:0] gpio_o,
    output logic [N_PINS-1:0] rise_o,
    output logic [N_PINS-1:0] fall_o,
    output logic [N_PINS-1:0] evt_o,
    output logic              irq_o
);

    logic [N_PINS-1:0]            s1_q,   s1_d;
    logic [N_PINS-1:0]            s2_q,   s2_d;
    logic [N_PINS-1:0]            lvl_q,  lvl_d;
    logic [N_PINS-1:0]            rise_q, rise_d;
    logic [N_PINS-1:0]            fall_q, fall_d;
    logic [N_PINS-1:0]            evt_q,  evt_d;
    logic                         irq_q,  irq_d;
    logic [N_PINS-1:0][CNT_W-1:0] cnt_q,  cnt_d;

    always_comb begin
        s1_d   = pad_c_i;
        s2_d   = s1_q;
        lvl_d  = lvl_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = '0;
        for (int unsigned i = 0; i < N_PINS; i++) begin
            if (!en_i[i] || (s2_q[i] == lvl_q[i])) begin
                // Disabled, or s2 agrees with the accepted level. Any
                // partial count is a glitch and is discarded.
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= filt_len_i) begin
                // The >= test makes a lowered L take effect at once.
                // cnt cannot pass L, so it never wraps even at maximum L.
                lvl_d[i]  = s2_q[i];
                rise_d[i] = s2_q[i];
                fall_d[i] = ~s2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // Set wins over clear when both happen in the same cycle.
        evt_d = (evt_q & ~evt_clr_i) | rise_d | fall_d;
        // irq is registered from the next evt value, so it lines up
        // with evt_o in the same cycle.
        irq_d = |evt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            lvl_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            evt_q  <= '0;
            irq_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
            irq_q  <= irq_d;
            cnt_q  <= cnt_d;
        end
    end

    assign gpio_o = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign evt_o  = evt_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Scoreboard testbench for gpio_in_filter.
//
// The driver advances a reference model once per rising edge and pushes
// the outputs it expects into a queue. A separate monitor pops one entry
// at each falling edge and compares it with the DUT outputs.
//
// The model describes the filter in terms of a "mismatch streak": the
// number of consecutive enabled cycles in which the synchronized pad has
// differed from the accepted level. An edge is accepted once that streak
// exceeds L.
module tb_gpio_in_filter;

    localparam int N = 9;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pad_c_i;
    logic [N-1:0] en_i;
    logic [W-1:0] filt_len_i;
    logic [N-1:0] evt_clr_i;
    logic [N-1:0] gpio_o;
    logic [N-1:0] rise_o;
    logic [N-1:0] fall_o;
    logic [N-1:0] evt_o;
    logic         irq_o;

    gpio_in_filter #(.N_PINS(N), .CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pad_c_i    (pad_c_i),
        .en_i       (en_i),
        .filt_len_i (filt_len_i),
        .evt_clr_i  (evt_clr_i),
        .gpio_o     (gpio_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .evt_o      (evt_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] gpio;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] evt;
        logic         irq;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Inputs currently applied to the DUT, and the inputs for the next cycle.
    logic         cur_rst, nx_rst;
    logic [N-1:0] cur_pad, nx_pad;
    logic [N-1:0] cur_en,  nx_en;
    logic [N-1:0] cur_clr, nx_clr;
    int           cur_L,   nx_L;

    // Reference model state.
    logic [N-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_evt;
    logic         m_irq;
    int           m_streak [N];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_zero();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_evt = '0;
        m_irq = 1'b0;
        for (int i = 0; i < N; i++) m_streak[i] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] nr, nf;
        if (cur_rst) begin
            model_zero();
            return;
        end
        nr = '0;
        nf = '0;
        for (int i = 0; i < N; i++) begin
            if (cur_en[i] && (m_s2[i] != m_lvl[i])) begin
                m_streak[i]++;
                if (m_streak[i] > cur_L) begin
                    m_lvl[i]    = m_s2[i];
                    nr[i]       = m_s2[i];
                    nf[i]       = ~m_s2[i];
                    m_streak[i] = 0;
                end
            end else begin
                m_streak[i] = 0;
            end
        end
        m_s2   = m_s1;
        m_s1   = cur_pad;
        m_rise = nr;
        m_fall = nf;
        m_evt  = (m_evt & ~cur_clr) | nr | nf;
        m_irq  = |m_evt;
    endtask

    // One clock. The model consumes the inputs applied during the cycle
    // that just ended. The next inputs are then applied 2 time units after
    // the edge. A newly asserted reset clears the model at once, because
    // the DUT reset is asynchronous.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_edge();
        cur_rst = nx_rst; cur_pad = nx_pad; cur_en = nx_en;
        cur_clr = nx_clr; cur_L = nx_L;
        if (cur_rst) model_zero();
        e.gpio = m_lvl; e.rise = m_rise; e.fall = m_fall; e.evt = m_evt; e.irq = m_irq;
        sb.push_back(e);
        #2;
        rst = cur_rst; pad_c_i = cur_pad; en_i = cur_en;
        evt_clr_i = cur_clr; filt_len_i = W'(cur_L);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Monitor: compare one scoreboard entry at each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gpio_o", gpio_o, e.gpio);
                chk("rise_o", rise_o, e.rise);
                chk("fall_o", fall_o, e.fall);
                chk("evt_o",  evt_o,  e.evt);
                chk("irq_o",  {{(N-1){1'b0}}, irq_o}, {{(N-1){1'b0}}, e.irq});
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending entries, expected 0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int mask;
        model_zero();
        // Reset with all pads high and L=0.
        cur_rst = 1'b1; cur_pad = '1; cur_en = '1; cur_clr = '0; cur_L = 0;
        rst = 1'b1; pad_c_i = '1; en_i = '1; evt_clr_i = '0; filt_len_i = '0;
        nx_rst = 1'b1; nx_pad = '1; nx_en = '1; nx_clr = '0; nx_L = 0;
        run(3);
        nx_rst = 1'b0;
        run(12);

        // Glitch filter on pin 2 with L=4.
        nx_pad = '0; nx_L = 4; nx_clr = '1;
        run(20);
        nx_clr = '0;
        nx_pad[2] = 1'b1; run(3);
        nx_pad[2] = 1'b0; run(20);
        nx_pad[2] = 1'b1; run(10);
        nx_pad[2] = 1'b0; run(15);

        // L lowered mid-count on pin 0.
        nx_L = 200; nx_pad[0] = 1'b1; run(50);
        nx_L = 10; run(20);

        // Enable gating on pin 5.
        nx_L = 3; nx_en[5] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            nx_pad[5] = ~nx_pad[5];
            run(10);
        end
        nx_pad[5] = 1'b1; nx_en[5] = 1'b1; run(15);

        // Held clear against an accepted edge on pin 1.
        nx_L = 2; nx_clr[1] = 1'b1; nx_pad[1] = 1'b1; run(15);
        nx_clr = '0; run(3);

        // Async reset mid-count with L=20.
        nx_L = 20; nx_pad = '0; nx_clr = '1; run(30);
        nx_clr = '0; nx_pad[3] = 1'b1; run(11);
        nx_rst = 1'b1; run(1);
        nx_rst = 1'b0; run(30);

        // Maximum L with a held level.
        nx_L = 255; nx_pad = '1; run(270);

        // Random phases.
        for (int ph = 0; ph < 30; ph++) begin
            int r, dur;
            r = $urandom_range(0, 9);
            if (r < 6)      nx_L = $urandom_range(0, 5);
            else if (r < 9) nx_L = $urandom_range(6, 40);
            else            nx_L = 255;
            case ($urandom_range(0, 2))
                0:       mask = 1;
                1:       mask = 7;
                default: mask = 31;
            endcase
            nx_en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            dur = $urandom_range(50, 300);
            for (int k = 0; k < dur; k++) begin
                for (int i = 0; i < N; i++)
                    if (($urandom & mask) == 0) nx_pad[i] = ~nx_pad[i];
                nx_clr = (($urandom & 3) == 0) ? N'($urandom) : '0;
                if ($urandom_range(0, 199) == 0) nx_L = $urandom_range(0, 8);
                nx_rst = ($urandom_range(0, 399) == 0);
                cycle();
            end
            nx_rst = 1'b0;
        end

        nx_clr = '0;
        run(3);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_in_filter.md
# gpio_in_filter

Input-conditioning stage between the GPIO pad cells' receive outputs (`C`) and the core's `gpio_in` bus. For each pin it provides:
- a two-flop synchronizer;
- a programmable-length glitch filter;
- single-cycle rise and fall strobes;
- sticky edge-event flags with a per-pin clear and a combined interrupt.

Pad outputs are asynchronous to `clk`, so only `gpio_o` may feed core logic.

## Interface
Parameters:
- `N_PINS`, default 9: number of conditioned pins.
- `CNT_W`, default 8: width of the filter counter and of `filt_len_i`.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high, applied to all flops.
- `pad_c_i`  in  N_PINS  raw pad receive values, asynchronous.
- `en_i`  in  N_PINS  per-pin filter enable, synchronous to `clk`.
- `filt_len_i`  in  CNT_W  filter length L, global, synchronous, may change at any time.
- `evt_clr_i`  in  N_PINS  per-pin clear of the sticky event flag.
- `gpio_o`  out  N_PINS  filtered, synchronized level to the core.
- `rise_o`  out  N_PINS  one-cycle strobe on an accepted 0→1 change.
- `fall_o`  out  N_PINS  one-cycle strobe on an accepted 1→0 change.
- `evt_o`  out  N_PINS  sticky flag, set by any accepted edge.
- `irq_o`  out  1  OR of all `evt_o` bits, registered.

## Operation
Each pin is an independent copy of the logic below; there is no cross-pin interaction except `irq_o`.

Synchronizer:
- `s1 <= pad_c_i[i]`, then `s2 <= s1`.
- It runs regardless of `en_i`.

Filter state:
- `lvl` is the accepted level and drives `gpio_o[i]` directly.
- `cnt` is a CNT_W-bit mismatch counter.

Per clock, in priority order:
1. `en_i[i]`=0: `cnt` <= 0, `lvl` holds, no strobes.
2. `s2 == lvl`: `cnt` <= 0, which discards any partial count as a glitch.
3. `s2 != lvl` and `cnt >= filt_len_i`: `lvl` <= `s2`, `cnt` <= 0, and the matching strobe is asserted next cycle.
4. Otherwise: `cnt` <= `cnt`+1.

Counter and threshold rules:
- The comparison is `>=`, so lowering L mid-count takes effect immediately without overshoot or wrap.
- `cnt` never exceeds 2^CNT_W−1: the maximum L triggers at `cnt` = L, so no saturation logic is needed.
- L=0 gives an acceptance on the first mismatch cycle; the filter is effectively bypassed apart from 1 register.

Strobes:
- `rise_o[i]` and `fall_o[i]` are registered.
- They are high for exactly the one cycle in which the new `lvl` first appears on `gpio_o`.
- They are mutually exclusive.

Event flag:
- Set on either strobe; cleared by `evt_clr_i[i]`.
- If set and clear occur in the same cycle, set wins.
- A held `evt_clr_i` keeps the flag clear except in cycles where an edge arrives.

Interrupt:
- `irq_o <= |evt_o_next`, i.e. it follows `evt_o` in the same cycle, driven from a flop.

Reset mid-operation:
- All state returns to 0 asynchronously: s1, s2, `lvl`, `cnt`, strobes, `evt_o`, `irq_o`.
- A pad held at 1 through reset is reported as a rising edge after 3+L cycles following deassertion.

## Timing
- Reset value of every output: 0.
- Latency for a pad change that is stable before rising edge E0 until acceptance:
  - `s1` at E0, `s2` at E1;
  - first mismatch cycle at E1, acceptance at E1+L;
  - `gpio_o` and strobe valid after edge E2+L, i.e. 3+L edges counting E0.
- Minimum accepted pulse width at `s2`: L+1 consecutive cycles. Shorter pulses produce no output activity.
- `en_i`: its effect is seen on the next edge. Re-enabling starts counting from 0.
- `filt_len_i` change: used on the next edge, for all pins.
- `evt_clr_i` → `evt_o` low: 1 cycle. `irq_o` low in the same cycle if no other flag is set.
- No combinational path from any input to any output.

## Test plan
- **Reset values:** assert `rst` with `pad_c_i`=all 1s, deassert with L=0. Required: all outputs 0 during reset; `gpio_o`=all 1s, `rise_o`=all 1s for 1 cycle and `evt_o`=all 1s on the 3rd edge; `irq_o`=1.
- **Glitch filter:** L=4, pin 2. Drive a 3-cycle high pulse → `gpio_o[2]` stays 0, no strobe. Drive a level held ≥5 cycles → `gpio_o[2]`=1 and `rise_o[2]` high on edge 7 after the change. Release → `fall_o[2]` on edge 7.
- **L lowered mid-count:** L=200, pin 0 mismatch held for 50 cycles, then set L=10. Required: acceptance on the next edge, exactly 1 `rise_o[0]` pulse.
- **Enable gating:** `en_i[5]`=0, toggle pad 5 slowly for 100 cycles → `gpio_o[5]`, strobes and `evt_o[5]` unchanged. Set `en_i[5]`=1 with the pad different from `lvl` → update after L+1 cycles.
- **Clear vs set:** hold `evt_clr_i[1]`=1 and produce an accepted edge on pin 1 → `evt_o[1]` is 1 for one cycle (set wins), then 0. `irq_o` tracks it.
- **Async reset mid-count:** L=20, pulse `rst` for 1 cycle at count 10 → all state 0 immediately; the full 3+L latency applies afterwards.
